mode_sched: RTL and testbench
=============================

Name: mode_sched

Overview:
- Round-robin scheduler that shares one counted run engine (IDLE/RUN/LAST sequencer plus a bounded counter) between NREQ requesters.
- Each requester asks for a run of programmable length. The scheduler grants one requester at a time, sequences the run, and pulses that requester's done.
- Sits between the mode-level control FSMs and the shared counting datapath.

Parameters:
- NREQ, 4: number of requesters (2..8).
- CNTW, 4: width of each run-length field and of the internal counter.

Ports:
- clk  in  1: clock; all logic on rising edge.
- rst  in  1: synchronous active-high reset.
- req  in  NREQ: level request per requester.
- len  in  NREQ*CNTW: per-requester run length. Field i is len[i*CNTW +: CNTW].
- gnt  out  NREQ: one-hot grant, registered; held for the whole run.
- done  out  NREQ: one-cycle completion pulse to the granted requester, registered.
- busy  out  1: high whenever the state is not IDLE, registered.
- cnt  out  CNTW: current run count, for the datapath.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: gnt=0, done=0, busy=0, cnt=0, state=IDLE, round-robin pointer=NREQ-1 (so req[0] has first priority).
- States:
  - IDLE: if req!=0, the arbiter picks the winner, then go to RUN.
  - RUN: if cnt==len_q, go to LAST.
  - LAST: unconditionally go to IDLE.
- Arbitration happens only in IDLE. Priority order starts at pointer+1, modulo NREQ. On grant, pointer takes the winner index.
- Entering RUN, the following load on the same edge:
  - gnt = one-hot winner
  - len_q = len field of the winner
  - cnt = 0
  - busy = 1
- In RUN, cnt increments by 1 each cycle. No wrap is possible, because exit occurs at cnt==len_q and len_q <= 2^CNTW-1.
- Timing for a request first seen in IDLE at cycle t with length L:
  - gnt high cycles t+1 .. t+L+2
  - RUN occupies L+1 cycles
  - done[winner] high at cycle t+L+2 (LAST)
  - IDLE at t+L+3
  - L=0 gives a one-cycle RUN.
- cnt returns to 0 on entry to IDLE.
- The len input is sampled only at grant. Later changes to len have no effect on the current run.
- Requester handshake:
  - The requester holds req until it sees done, then deasserts req on the next edge.
  - A req still high while in IDLE is treated as a new request.
  - Dropping req during RUN or LAST does not abort the run; done still pulses.
- Simultaneous requests: exactly one is granted, per the round-robin rule. Losers stay pending with no time-out.
- Back-to-back: minimum one IDLE cycle between runs. Two requesters each held continuously alternate grants.
- Reset mid-run:
  - gnt, done and busy clear on the next edge.
  - No done pulse is produced.
  - The pointer resets to NREQ-1.
- gnt and done are always one-hot or zero. done is only ever asserted on the bit where gnt is also asserted.

Optional Feature:
- Macro: MODE_SCHED_ABORT_EN.
- Defined:
  - Adds input abort (1) and output aborted (1).
  - abort=1 in RUN moves the FSM to IDLE on the next edge, clears gnt and cnt, and suppresses done. aborted pulses for one cycle in that IDLE cycle.
  - abort in IDLE or LAST is ignored. LAST still completes with done.
  - The pointer keeps the aborted winner.
- Not defined: no abort or aborted ports; every run completes.

Decomposition:
- Package mode_sched_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, LAST=2'd2.
  - Default NREQ and CNTW.
  - Function for round-robin rotation (index modulo NREQ).
- Sub-module rr_arb:
  - Inputs: req, pointer. Output: one-hot winner plus encoded winner index.
  - Purely combinational; reused by other sequencers.
- The FSM, counter and output registers live in mode_sched.

Test Plan:
- Reset then single request: req=4'b0001, len0=3 at t. Required: gnt=0001 for t+1..t+5, cnt goes 0,1,2,3 in t+1..t+4, done=0001 at t+5, busy low at t+6.
- Zero length: req[2] with len2=0. Required: one RUN cycle, then done=0100 two cycles after the request is first seen.
- Round-robin: req=4'b1011 held, all lengths=1. Grant order must be 0,1,3,0,1,3, with exactly one IDLE cycle between each LAST and the next RUN.
- Requests during a run: req[1] raised while req[0] is in RUN. Required: no grant change until IDLE, then gnt=0010. len1 changed during its own run has no effect on the run length.
- Reset mid-run: rst=1 while cnt=2 of a len=9 run. Required: next cycle gnt=0, done=0, busy=0, cnt=0. A subsequent req[0] is granted first.
- With MODE_SCHED_ABORT_EN: abort at cnt=4 of a len=9 run. Required: IDLE next cycle, aborted=1 for one cycle, done never pulses. A following request is granted normally.

Source files
------------

// File: rtl/mode_sched_pkg.sv
// mode_sched_pkg: shared types, defaults and the round-robin helper
// used by the run-engine scheduler and its arbiter.
package mode_sched_pkg;

    // Sequencer states of the shared run engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2
    } state_t;

    // Default number of requesters and run-length/counter width.
    localparam int DEF_NREQ = 4;
    localparam int DEF_CNTW = 4;

    // Index reached by stepping 'offset' places past 'base' in a ring of n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/mode_sched_rr_arb.sv
// rr_arb: purely combinational round-robin arbiter. The search starts
// one place after 'ptr' and wraps, so the last winner has lowest priority.
module rr_arb
    import mode_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IDXW-1:0] win_idx,
    output logic            any
);

    logic            found;
    logic [IDXW-1:0] idx;

    // Walk the ring from ptr+1 and keep the first active request.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDXW'(rr_index(int'(ptr), k, NREQ));
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mode_sched.sv
// mode_sched: round-robin scheduler sharing one counted run engine
// (IDLE/RUN/LAST plus a bounded counter) between NREQ requesters.
// Optional abort support is compiled in with MODE_SCHED_ABORT_EN.
module mode_sched
    import mode_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int CNTW = DEF_CNTW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CNTW-1:0] len,
`ifdef MODE_SCHED_ABORT_EN
    input  logic                 abort,
    output logic                 aborted,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic [CNTW-1:0]      cnt
);

    localparam int IDXW = $clog2(NREQ);

    state_t          state;
    state_t          next_state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_d;
    logic [IDXW-1:0] win_idx;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] gnt_d;
    logic [NREQ-1:0] done_d;
    logic            win_any;
    logic            busy_d;
    logic            abort_hit;
    logic [CNTW-1:0] cnt_d;
    logic [CNTW-1:0] len_q;
    logic [CNTW-1:0] len_d;

`ifdef MODE_SCHED_ABORT_EN
    logic aborted_d;
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    rr_arb #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .win_oh (win_oh),
        .win_idx(win_idx),
        .any    (win_any)
    );

    // State register of the run sequencer.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decision: grant from IDLE, leave RUN at the programmed length.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (win_any) next_state = RUN;
            RUN: begin
                if (abort_hit)         next_state = IDLE;
                else if (cnt == len_q) next_state = LAST;
            end
            LAST:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, counter, latched length and pointer.
    always_comb begin
        gnt_d  = gnt;
        done_d = '0;
        cnt_d  = cnt;
        len_d  = len_q;
        ptr_d  = ptr;
        busy_d = (next_state != IDLE);
`ifdef MODE_SCHED_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                gnt_d = '0;
                cnt_d = '0;
                if (win_any) begin
                    gnt_d = win_oh;
                    len_d = len[int'(win_idx)*CNTW +: CNTW];
                    ptr_d = win_idx;
                end
            end
            RUN: begin
                if (abort_hit) begin
                    gnt_d = '0;
                    cnt_d = '0;
`ifdef MODE_SCHED_ABORT_EN
                    aborted_d = 1'b1;
`endif
                end else if (cnt == len_q) begin
                    done_d = gnt;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            LAST: begin
                gnt_d = '0;
                cnt_d = '0;
            end
            default: begin
                gnt_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    // Output and datapath registers; reset gives req[0] first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
            len_q <= '0;
            ptr   <= IDXW'(NREQ - 1);
`ifdef MODE_SCHED_ABORT_EN
            aborted <= 1'b0;
`endif
        end else begin
            gnt   <= gnt_d;
            done  <= done_d;
            busy  <= busy_d;
            cnt   <= cnt_d;
            len_q <= len_d;
            ptr   <= ptr_d;
`ifdef MODE_SCHED_ABORT_EN
            aborted <= aborted_d;
`endif
        end
    end

endmodule

// File: tb/tb_mode_sched.sv
// tb_mode_sched: scoreboard bench for mode_sched. The driver keeps a
// run-level model (who wins, when the run starts and ends) and queues one
// record per granted run; a negedge monitor turns the record at the head
// of the queue into the expected gnt/done/busy/cnt for each cycle.
module tb_mode_sched;

    localparam int NREQ = 4;
    localparam int CNTW = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*CNTW-1:0] len;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic                 busy;
    logic [CNTW-1:0]      cnt;
`ifdef MODE_SCHED_ABORT_EN
    logic                 abort;
    logic                 aborted;
`endif

    mode_sched #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .len    (len),
`ifdef MODE_SCHED_ABORT_EN
        .abort  (abort),
        .aborted(aborted),
`endif
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt    (cnt)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Cycle index: outputs seen during cycle k come from rising edge k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int w;
        int l;
        int start;
        int end_c;
        int done_c;
    } run_t;

    run_t sb[$];
    int   m_ptr        = NREQ - 1;
    int   m_idle_from  = 0;
    int   exp_abort_cyc = -10;
    int   checks   = 0;
    int   failures = 0;
    logic [NREQ-1:0] rq;

    // One comparison; mismatches print a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Run-level model: inputs set now are seen at the edge closing cycle k.
    task automatic model_step(input int k, input logic ab);
        int w;
        int l;
        if (rst) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].end_c > k) begin
                    sb[i].end_c  = k;
                    sb[i].done_c = -1;
                end
            end
            m_ptr       = NREQ - 1;
            m_idle_from = k + 1;
            return;
        end
        if (ab && sb.size() > 0 && k >= sb[$].start && k <= sb[$].start + sb[$].l) begin
            sb[$].end_c   = k;
            sb[$].done_c  = -1;
            exp_abort_cyc = k + 1;
            m_idle_from   = k + 1;
        end
        if (k >= m_idle_from && req != '0) begin
            w = -1;
            for (int j = 1; j <= NREQ; j++) begin
                int idx;
                idx = (m_ptr + j) % NREQ;
                if (w < 0 && req[idx]) w = idx;
            end
            l = int'(len[w*CNTW +: CNTW]);
            sb.push_back('{w: w, l: l, start: k + 1, end_c: k + l + 2, done_c: k + l + 2});
            m_ptr       = w;
            m_idle_from = k + l + 3;
        end
    endtask

    // Set the inputs for the coming edge and advance the model.
    task automatic drive(input logic r, input logic [NREQ-1:0] q, input logic [NREQ*CNTW-1:0] ln, input logic ab);
        rst = r;
        req = q;
        len = ln;
`ifdef MODE_SCHED_ABORT_EN
        abort = ab;
        model_step(cyc, ab);
`else
        model_step(cyc, 1'b0);
`endif
    endtask

    task automatic applyStimulus(input logic r, input logic [NREQ-1:0] q, input logic [NREQ*CNTW-1:0] ln, input logic ab);
        @(posedge clk);
        #1;
        drive(r, q, ln, ab);
    endtask

    task automatic hold(input logic [NREQ-1:0] q, input logic [NREQ*CNTW-1:0] ln, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, q, ln, 1'b0);
    endtask

    int              mc;
    bit              mact;
    int              exp_cnt;
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ed;

    // Monitor: expected outputs for this cycle come from the queue head.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            mc = cyc;
            while (sb.size() > 0 && sb[0].end_c < mc) void'(sb.pop_front());
            mact    = (sb.size() > 0) && (mc >= sb[0].start);
            eg      = '0;
            ed      = '0;
            exp_cnt = 0;
            if (mact) begin
                eg = NREQ'(1 << sb[0].w);
                if (mc == sb[0].done_c) ed = eg;
                exp_cnt = mc - sb[0].start;
            end
            checkOutput("gnt", 32'(gnt), 32'(eg));
            checkOutput("done", 32'(done), 32'(ed));
            checkOutput("busy", 32'(busy), 32'(mact));
            if (!mact || mc < sb[0].end_c) checkOutput("cnt", 32'(cnt), 32'(exp_cnt));
`ifdef MODE_SCHED_ABORT_EN
            checkOutput("aborted", 32'(aborted), 32'(mc == exp_abort_cyc));
`endif
            if (mact && mc == sb[0].end_c) void'(sb.pop_front());
        end
    end

    // Directed scenarios followed by a randomized requester population.
    initial begin
        rst = 1'b1;
        req = '0;
        len = '0;
`ifdef MODE_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        rq  = '0;
        repeat (3) applyStimulus(1'b1, '0, '0, 1'b0);

        $display("[TB] single request, len0=3");
        hold(4'b0001, 16'h0003, 6);
        hold(4'b0000, 16'h0000, 3);

        $display("[TB] zero length on req[2]");
        hold(4'b0100, 16'h0000, 3);
        hold(4'b0000, 16'h0000, 3);

        $display("[TB] round robin 1011 after reset");
        repeat (2) applyStimulus(1'b1, '0, '0, 1'b0);
        hold(4'b1011, 16'h1111, 24);
        hold(4'b0000, 16'h0000, 4);

        $display("[TB] request during run, len1 changed mid-run");
        hold(4'b0001, 16'h0025, 3);
        hold(4'b0011, 16'h0025, 5);
        hold(4'b0010, 16'h0025, 1);
        hold(4'b0010, 16'h00F5, 4);
        hold(4'b0000, 16'h0000, 3);

        $display("[TB] reset mid-run");
        hold(4'b0001, 16'h0009, 3);
        applyStimulus(1'b1, 4'b0001, 16'h0009, 1'b0);
        hold(4'b0011, 16'h0011, 4);
        hold(4'b0010, 16'h0011, 6);
        hold(4'b0000, 16'h0000, 4);

`ifdef MODE_SCHED_ABORT_EN
        $display("[TB] abort at cnt=4");
        hold(4'b0001, 16'h0009, 5);
        applyStimulus(1'b0, 4'b0000, 16'h0009, 1'b1);
        hold(4'b0001, 16'h0002, 5);
        hold(4'b0000, 16'h0000, 4);
`endif

        $display("[TB] random phase");
        rq = '0;
        for (int n = 0; n < 1500; n++) begin
            logic r;
            logic ab;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!rq[i] && $urandom_range(0, 3) == 0) rq[i] = 1'b1;
                else if (rq[i] && $urandom_range(0, 63) == 0) rq[i] = 1'b0;
            end
            if (sb.size() > 0 && sb[$].done_c == cyc) rq[sb[$].w] = 1'b0;
            r  = ($urandom_range(0, 299) == 0);
            ab = ($urandom_range(0, 15) == 0);
            drive(r, rq, NREQ*CNTW'($urandom()), ab);
        end

        hold(4'b0000, 16'h0000, 24);
        checkOutput("drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
